// File: rtl/gmii_pkg.sv
// rtl/gmii_pkg.sv - shared constants and word builder for the GMII to 18-bit FIFO packer
package gmii_pkg;

  localparam int FIFO_W      = 18;
  localparam int HI_FLAG_BIT = 17;
  localparam int LO_FLAG_BIT = 16;
  localparam logic [7:0]        SFD       = 8'hD5;
  localparam logic [FIFO_W-1:0] IDLE_WORD = '0;

  // High byte is always valid in a data word; only the low byte may be absent.
  function automatic logic [FIFO_W-1:0] make_word(input logic       lo_valid,
                                                  input logic [7:0] hi,
                                                  input logic [7:0] lo);
    logic [FIFO_W-1:0] w;
    w              = IDLE_WORD;
    w[HI_FLAG_BIT] = 1'b1;
    w[LO_FLAG_BIT] = lo_valid;
    w[15:8]        = hi;
    w[7:0]         = lo;
    return w;
  endfunction

endpackage

// File: rtl/gmii_byte_pairer.sv
// rtl/gmii_byte_pairer.sv - holds one byte and emits a two-byte word (or a half word on flush)
module gmii_byte_pairer
  import gmii_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              flush_i,
  input  logic [7:0]        byte_i,
  output logic [FIFO_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [7:0] hold_q, hold_d;
  logic       occ_q, occ_d;

  always_comb begin
    hold_d       = hold_q;
    occ_d        = occ_q;
    word_o       = IDLE_WORD;
    word_valid_o = 1'b0;
    if (push_i) begin
      if (occ_q) begin
        word_o       = make_word(1'b1, hold_q, byte_i);
        word_valid_o = 1'b1;
        occ_d        = 1'b0;
      end else begin
        hold_d = byte_i;
        occ_d  = 1'b1;
      end
    end else if (flush_i) begin
      if (occ_q) begin
        word_o       = make_word(1'b0, hold_q, 8'h00);
        word_valid_o = 1'b1;
      end
      occ_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= 8'h00;
      occ_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/gmii2fifo18.sv
// rtl/gmii2fifo18.sv - GMII RX byte stream to 18-bit FIFO words with post-frame idle gap
// Optional preamble/SFD stripping when GMII2FIFO18_PREAMBLE_STRIP_EN is defined.
module gmii2fifo18
  import gmii_pkg::*;
#(
  parameter logic [3:0] Gap = 4'h4
) (
  input  logic        gmii_rx_clk,
  input  logic        sys_rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic [17:0] din,
  input  logic        full,
  output logic        wr_en,
  output logic        wr_clk
);

`ifdef GMII2FIFO18_PREAMBLE_STRIP_EN
  localparam logic STRIP_EN = 1'b1;
`else
  localparam logic STRIP_EN = 1'b0;
`endif

  logic              active_q, active_d;
  logic              sfd_seen_q, sfd_seen_d;
  logic [3:0]        gap_q, gap_d;
  logic [FIFO_W-1:0] din_q, din_d;
  logic              wr_en_q, wr_en_d;
  logic              push, flush;
  logic [FIFO_W-1:0] pair_word;
  logic              pair_valid;

  gmii_byte_pairer u_pairer (
    .clk_i        (gmii_rx_clk),
    .rst_i        (sys_rst),
    .push_i       (push),
    .flush_i      (flush),
    .byte_i       (gmii_rxd),
    .word_o       (pair_word),
    .word_valid_o (pair_valid)
  );

  always_comb begin
    active_d   = active_q;
    sfd_seen_d = sfd_seen_q;
    gap_d      = gap_q;
    din_d      = din_q;
    wr_en_d    = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    if (gmii_rx_dv) begin
      active_d = 1'b1;
      // A new frame cuts short any delimiter still being written.
      if (!active_q) gap_d = 4'd0;
      if (STRIP_EN && !sfd_seen_q) begin
        if (gmii_rxd == SFD) sfd_seen_d = 1'b1;
      end else begin
        push = 1'b1;
      end
    end else if (active_q) begin
      active_d   = 1'b0;
      flush      = 1'b1;
      sfd_seen_d = 1'b0;
      gap_d      = (STRIP_EN && !sfd_seen_q) ? 4'd0 : Gap;
    end else if (gap_q != 4'd0) begin
      gap_d   = gap_q - 4'd1;
      din_d   = IDLE_WORD;
      wr_en_d = !full;
    end
    // A word dropped on full still consumes the pair; there is no retry.
    if (pair_valid) begin
      din_d   = pair_word;
      wr_en_d = !full;
    end
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (sys_rst) begin
      active_q   <= 1'b0;
      sfd_seen_q <= 1'b0;
      gap_q      <= 4'd0;
      din_q      <= IDLE_WORD;
      wr_en_q    <= 1'b0;
    end else begin
      active_q   <= active_d;
      sfd_seen_q <= sfd_seen_d;
      gap_q      <= gap_d;
      din_q      <= din_d;
      wr_en_q    <= wr_en_d;
    end
  end

  assign din    = din_q;
  assign wr_en  = wr_en_q;
  assign wr_clk = gmii_rx_clk;

endmodule

// File: tb/tb_gmii2fifo18.sv
// tb/tb_gmii2fifo18.sv - self-checking bench for gmii2fifo18 against a frame-level reference model
module tb_gmii2fifo18;

  localparam int GAP  = 4;
  localparam int MAXC = 2000;
`ifdef GMII2FIFO18_PREAMBLE_STRIP_EN
  localparam bit STRIP = 1'b1;
`else
  localparam bit STRIP = 1'b0;
`endif
  localparam logic PAIR_WR = !STRIP;

  logic        gmii_rx_clk = 1'b0;
  logic        sys_rst;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic [17:0] din;
  logic        full;
  logic        wr_en;
  logic        wr_clk;

  gmii2fifo18 #(.Gap(4'h4)) dut (
    .gmii_rx_clk (gmii_rx_clk),
    .sys_rst     (sys_rst),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rxd    (gmii_rxd),
    .din         (din),
    .full        (full),
    .wr_en       (wr_en),
    .wr_clk      (wr_clk)
  );

  always #4 gmii_rx_clk = ~gmii_rx_clk;

  int          checks = 0;
  int          errors = 0;
  int          n = 0;
  logic        dv_a    [MAXC];
  logic [7:0]  rxd_a   [MAXC];
  logic        full_a  [MAXC];
  logic        wr_exp  [MAXC];
  logic [17:0] din_exp [MAXC];
  logic        act_wr  [MAXC];
  logic [17:0] act_din [MAXC];

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %05h exp %05h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge gmii_rx_clk);
    #1;
  endtask

  task automatic add_byte(input logic [7:0] b);
    dv_a[n] = 1'b1; rxd_a[n] = b; full_a[n] = 1'b0; n++;
  endtask

  task automatic add_idle(input int k);
    for (int i = 0; i < k; i++) begin
      dv_a[n] = 1'b0; rxd_a[n] = 8'($urandom_range(0, 255)); full_a[n] = 1'b0; n++;
    end
  endtask

  task automatic emit(input int c, input logic [17:0] w);
    din_exp[c] = w;
    wr_exp[c]  = !full_a[c];
  endtask

  // Words appear one cycle after the edge that completes them; the gap follows the frame end.
  task automatic build_expect();
    int t, s, e, ns;
    bit started;
    logic [7:0] pay[$];
    int pc[$];
    for (int i = 0; i < n; i++) begin wr_exp[i] = 1'b0; din_exp[i] = '0; end
    t = 0;
    while (t < n) begin
      if (!dv_a[t]) begin
        t++;
      end else begin
        s = t;
        while (t < n && dv_a[t]) t++;
        e = t;
        pay.delete(); pc.delete();
        started = !STRIP;
        for (int i = s; i < e; i++) begin
          if (started) begin pay.push_back(rxd_a[i]); pc.push_back(i); end
          else if (rxd_a[i] == 8'hD5) started = 1'b1;
        end
        for (int k = 0; k + 1 < pay.size(); k += 2)
          emit(pc[k+1], {2'b11, pay[k], pay[k+1]});
        if (pay.size() % 2 == 1) emit(e, {2'b10, pay[pay.size()-1], 8'h00});
        if (started) begin
          ns = e;
          while (ns < n && !dv_a[ns]) ns++;
          for (int g = 1; g <= GAP; g++) if (e + g < ns) emit(e + g, 18'h0);
        end
      end
    end
  endtask

  task automatic check_seg(input string tag, input int a, input int b, input logic [17:0] exp[$]);
    logic [17:0] got[$];
    for (int t = a; t < b; t++) if (act_wr[t]) got.push_back(act_din[t]);
    chk($sformatf("%s_count", tag), 18'(got.size()), 18'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), (i < got.size()) ? got[i] : 18'hx, exp[i]);
  endtask

  initial begin
    int seg[8];
    int rnd_start;
    logic [17:0] eq[$];

    sys_rst = 1'b1; gmii_rx_dv = 1'b0; gmii_rxd = 8'h00; full = 1'b0;
    step();
    chk("rst_din", din, 18'h0);
    chk("rst_wr_en", {17'b0, wr_en}, 18'h0);
    chk("wr_clk", {17'b0, wr_clk}, {17'b0, gmii_rx_clk});
    step();
    sys_rst = 1'b0;

    seg[0] = n;
    add_byte(8'h11); add_byte(8'h22); add_byte(8'h33); add_byte(8'h44); add_idle(8);
    seg[1] = n;
    add_byte(8'hAA); add_byte(8'hBB); add_byte(8'hCC); add_idle(8);
    seg[2] = n;
    for (int i = 1; i <= 8; i++) begin
      add_byte(8'(i));
      if (i == 4) full_a[n-1] = 1'b1;
    end
    add_idle(8);
    seg[3] = n;
    add_byte(8'h01); add_byte(8'h02); add_idle(2); add_byte(8'h03); add_byte(8'h04); add_idle(8);
    seg[4] = n;
    for (int i = 0; i < 7; i++) add_byte(8'h55);
    add_byte(8'hD5); add_byte(8'hDE); add_byte(8'hAD); add_idle(8);
    seg[5] = n;
    add_byte(8'h55); add_byte(8'h55); add_idle(8);
    seg[6] = n;
    rnd_start = n;
    for (int f = 0; f < 25; f++) begin
      int len;
      int sfd_at;
      len = $urandom_range(1, 20);
      sfd_at = $urandom_range(0, len);
      for (int i = 0; i < len; i++) add_byte((i == sfd_at) ? 8'hD5 : 8'($urandom_range(0, 255)));
      add_idle($urandom_range(1, 7));
    end
    add_idle(GAP + 2);
    for (int t = rnd_start; t < n; t++) full_a[t] = ($urandom_range(0, 7) == 0);

    build_expect();

    for (int t = 0; t < n; t++) begin
      gmii_rx_dv = dv_a[t]; gmii_rxd = rxd_a[t]; full = full_a[t];
      step();
      act_wr[t] = wr_en; act_din[t] = din;
      chk($sformatf("wr_en_c%0d", t), {17'b0, wr_en}, {17'b0, wr_exp[t]});
      if (wr_exp[t]) chk($sformatf("din_c%0d", t), din, din_exp[t]);
    end

`ifndef GMII2FIFO18_PREAMBLE_STRIP_EN
    eq = '{18'h31122, 18'h33344, 18'h0, 18'h0, 18'h0, 18'h0};
    check_seg("four_byte", seg[0], seg[1], eq);
    eq = '{18'h3AABB, 18'h2CC00, 18'h0, 18'h0, 18'h0, 18'h0};
    check_seg("odd_frame", seg[1], seg[2], eq);
    eq = '{18'h30102, 18'h30506, 18'h30708, 18'h0, 18'h0, 18'h0, 18'h0};
    check_seg("full_drop", seg[2], seg[3], eq);
    eq = '{18'h30102, 18'h0, 18'h30304, 18'h0, 18'h0, 18'h0, 18'h0};
    check_seg("back2back", seg[3], seg[4], eq);
`else
    eq = '{18'h3DEAD, 18'h0, 18'h0, 18'h0, 18'h0};
    check_seg("sfd_strip", seg[4], seg[5], eq);
    eq = {};
    check_seg("no_sfd", seg[5], seg[6], eq);
`endif

    full = 1'b0;
    gmii_rx_dv = 1'b1; gmii_rxd = 8'h10; step();
    gmii_rxd = 8'h20; step();
    chk("pre_rst_wr", {17'b0, wr_en}, {17'b0, PAIR_WR});
    if (PAIR_WR) chk("pre_rst_din", din, 18'h31020);
    gmii_rxd = 8'h30; step();
    sys_rst = 1'b1; gmii_rxd = 8'h77; step();
    chk("mid_rst_din0", din, 18'h0);
    chk("mid_rst_wr0", {17'b0, wr_en}, 18'h0);
    step();
    chk("mid_rst_din1", din, 18'h0);
    chk("mid_rst_wr1", {17'b0, wr_en}, 18'h0);
    sys_rst = 1'b0; gmii_rxd = 8'h40; step();
    chk("post_rst_hold", {17'b0, wr_en}, 18'h0);
    gmii_rxd = 8'h50; step();
    chk("post_rst_wr", {17'b0, wr_en}, {17'b0, PAIR_WR});
    if (PAIR_WR) chk("post_rst_din", din, 18'h34050);
    gmii_rx_dv = 1'b0; step();
    chk("post_rst_end", {17'b0, wr_en}, 18'h0);
    for (int g = 0; g < GAP; g++) begin
      step();
      chk($sformatf("post_rst_gap%0d", g), {17'b0, wr_en}, {17'b0, PAIR_WR});
    end
    step();
    chk("post_rst_idle", {17'b0, wr_en}, 18'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
